// File: rtl/sf_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sf_seq
//  Description : Capture-then-filter sequencer for a moving-window smoother.
//                Captures LEN ADC samples into an external buffer. It then
//                replays every M-sample window through an external
//                accumulator and strobes each window sum. Optional abort
//                support is compiled in with the macro SF_SEQ_ABORT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module sf_seq #(
    parameter int M   = 51,
    parameter int LEN = 1000,
    parameter int AW  = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          adc_valid,
    input  logic [7:0]    adc_data,
    output logic          adc_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          acc_ld,
    output logic          acc_en,
    output logic          out_stb,
    output logic [AW-1:0] out_idx,
    output logic          busy,
    output logic          done
);

    // Counters carry one spare bit so LEN == 2**AW can be counted.
    localparam int            c_cw       = AW + 1;
    localparam logic [AW:0]   c_len_last = c_cw'(LEN - 1);
    localparam logic [AW:0]   c_k_last   = c_cw'(M - 1);
    localparam logic [AW:0]   c_i_last   = c_cw'(LEN - M);
    localparam logic [AW:0]   c_one      = c_cw'(1);
    localparam logic [AW-1:0] c_one_a    = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_FILTER  = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t        r_state;
    logic [AW:0]   r_cnt;      // accepted-sample count, doubles as write address
    logic [AW:0]   r_i;        // window index of the read on rd_en
    logic [AW:0]   r_k;        // tap index of the read on rd_en
    logic          r_rd_en;
    logic [AW-1:0] r_rd_addr;
    logic          r_acc_ld;
    logic          r_acc_en;
    logic          r_last_acc; // accumulator is adding the last tap of a window
    logic [AW-1:0] r_idx1;     // window index, delayed to line up with r_last_acc
    logic          r_out_stb;
    logic [AW-1:0] r_out_idx;
    logic          r_busy;
    logic          r_done;
    logic          r_ready;
    logic          r_drain;    // second DRAIN cycle marker
    logic          w_accept;

`ifdef SF_SEQ_ABORT_EN
    logic w_abort_hit;
    assign w_abort_hit = abort & ((r_state == S_CAPTURE) | (r_state == S_FILTER));
`else
    // Abort is not honoured in this build; the port stays for pin compatibility.
    logic w_unused_abort;
    assign w_unused_abort = abort;
`endif

    assign w_accept  = adc_valid & r_ready;

    // Write port is a direct pass-through of the accepted ADC sample.
    assign wr_en     = w_accept;
    assign wr_addr   = r_cnt[AW-1:0];
    assign wr_data   = adc_data;

    assign adc_ready = r_ready;
    assign rd_en     = r_rd_en;
    assign rd_addr   = r_rd_addr;
    assign acc_ld    = r_acc_ld;
    assign acc_en    = r_acc_en;
    assign out_stb   = r_out_stb;
    assign out_idx   = r_out_idx;
    assign busy      = r_busy;
    assign done      = r_done;

    // Sequencer state, read-address generation and the accumulator/strobe pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_i        <= '0;
            r_k        <= '0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_acc_ld   <= 1'b0;
            r_acc_en   <= 1'b0;
            r_last_acc <= 1'b0;
            r_idx1     <= '0;
            r_out_stb  <= 1'b0;
            r_out_idx  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b0;
            r_drain    <= 1'b0;
        end else begin
            // Buffer data lands one cycle after the read; the sum is complete
            // one cycle after the last tap has been added.
            r_acc_en   <= r_rd_en;
            r_acc_ld   <= r_rd_en & (r_k == '0);
            r_last_acc <= r_rd_en & (r_k == c_k_last);
            r_idx1     <= r_i[AW-1:0];
            r_out_stb  <= r_last_acc;
            if (r_last_acc) begin
                r_out_idx <= r_idx1;
            end
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_CAPTURE;
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (w_accept) begin
                        if (r_cnt == c_len_last) begin
                            r_state   <= S_FILTER;
                            r_ready   <= 1'b0;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= '0;
                            r_i       <= '0;
                            r_k       <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_one;
                        end
                    end
                end
                S_FILTER: begin
                    if (r_k == c_k_last) begin
                        if (r_i == c_i_last) begin
                            r_state <= S_DRAIN;
                            r_rd_en <= 1'b0;
                            r_drain <= 1'b0;
                        end else begin
                            r_i       <= r_i + c_one;
                            r_k       <= '0;
                            r_rd_addr <= r_i[AW-1:0] + c_one_a;
                        end
                    end else begin
                        r_k       <= r_k + c_one;
                        r_rd_addr <= r_rd_addr + c_one_a;
                    end
                end
                S_DRAIN: begin
                    if (r_drain) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

`ifdef SF_SEQ_ABORT_EN
            // Abort wins over everything above and kills reads still in flight.
            if (w_abort_hit) begin
                r_state    <= S_IDLE;
                r_ready    <= 1'b0;
                r_busy     <= 1'b0;
                r_rd_en    <= 1'b0;
                r_acc_en   <= 1'b0;
                r_acc_ld   <= 1'b0;
                r_last_acc <= 1'b0;
                r_out_stb  <= 1'b0;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: doc/sf_seq.md
SF_SEQ -- requirements
Module: sf_seq

Interface
REQ-001 Parameter M, default 51: smoothing window length in samples; legal range 1 <= M <= LEN.
REQ-002 Parameter LEN, default 1000: samples captured per run; legal range 1 <= LEN <= 1024.
REQ-003 Parameter AW, default 10: sample-buffer address width.
REQ-004 Port clk, input, 1: single clock, rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-high.
REQ-006 Port start, input, 1: level-sampled run request.
REQ-007 Port abort, input, 1: cancels the run in progress.
REQ-008 Port adc_valid, input, 1: an ADC sample is offered.
REQ-009 Port adc_data, input, 8: ADC sample value.
REQ-010 Port adc_ready, output, 1: the block accepts a sample.
REQ-011 Port wr_en, wr_addr[AW], wr_data[8], outputs: sample-buffer write port.
REQ-012 Port rd_en, rd_addr[AW], outputs: sample-buffer read port; the buffer returns data 1 cycle after rd_en.
REQ-013 Port acc_ld, acc_en, outputs, 1 each: filter accumulator controls; acc_ld loads, acc_en adds.
REQ-014 Port out_stb, output, 1: the accumulator holds the window sum for out_idx.
REQ-015 Port out_idx, output, AW: index of the current output.
REQ-016 Port busy, output, 1: a run is in progress.
REQ-017 Port done, output, 1: 1-cycle pulse marking run completion.

Function
REQ-018 The block SHALL implement states IDLE, CAPTURE, FILTER, DRAIN and DONE.
REQ-019 IDLE: start=1 SHALL move to CAPTURE on the next edge and clear the sample counter; start SHALL be ignored in all other states.
REQ-020 CAPTURE: adc_ready SHALL be 1; on each adc_valid&adc_ready, wr_en=1, wr_addr=count, wr_data=adc_data (combinational), then count++.
REQ-021 After the LEN-th accepted sample, the block SHALL enter FILTER on the next edge; adc_ready SHALL be 0 in every other state.
REQ-022 FILTER: for i = 0..LEN-M and k = 0..M-1, one read per cycle with rd_en=1, rd_addr=i+k, issued back-to-back with no bubbles (k inner loop).
REQ-023 The cycle after each read, acc_en=1; acc_ld=1 additionally when that read had k=0.
REQ-024 out_stb=1 with out_idx=i SHALL assert the cycle after acc_en for k=M-1; this coincides with the next window's acc_ld.
REQ-025 Total FILTER duration SHALL be (LEN-M+1)*M cycles; after the last read, the block SHALL go to DRAIN.
REQ-026 DRAIN SHALL last exactly 2 cycles, covering the final acc_en and out_stb.
REQ-027 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-028 busy SHALL be 1 in CAPTURE, FILTER and DRAIN, and 0 in IDLE and DONE.
REQ-029 Counters SHALL be AW+1 bits wide; i+k SHALL never exceed LEN-1, so no address wraps.
REQ-030 If M=1, each output SHALL be a single read with acc_ld=acc_en=1.
REQ-031 If M=LEN, FILTER SHALL produce exactly one output.
REQ-032 wr_en and rd_en SHALL never be 1 in the same cycle.

Reset
REQ-033 When rst=1, the block SHALL asynchronously enter IDLE and clear all counters.
REQ-034 When rst=1, busy, done, adc_ready, wr_en, rd_en, acc_ld, acc_en and out_stb SHALL be 0, and wr_addr, rd_addr and out_idx SHALL be 0.
REQ-035 Reset asserted mid-run SHALL discard the run; after rst falls, no done and no out_stb SHALL occur until a new start.

Configuration
REQ-036 Macro SF_SEQ_ABORT_EN defined: abort=1 in CAPTURE or FILTER SHALL force IDLE on the next edge, with no done and no further out_stb; reads already in flight SHALL not produce out_stb.
REQ-037 Macro SF_SEQ_ABORT_EN undefined: the abort port SHALL remain present, be ignored, and add no logic.

Verification (M=3, LEN=8 unless stated)
REQ-038 Reset-value scenario: rst pulse at time 0 -> all outputs at REQ-034 values, state IDLE.
REQ-039 Full-run scenario: start, then 8 samples 10..80 with continuous adc_valid -> wr_addr 0..7; FILTER lasts 18 cycles; out_stb 6 times with out_idx 0..5; done 3 cycles after the last read.
REQ-040 Back-pressure scenario: adc_valid toggled 1/0 -> exactly 8 writes at the correct addresses; FILTER starts 1 cycle after the 8th write.
REQ-041 Mid-run reset scenario: rst asserted at FILTER read 7 -> immediate IDLE; no done; the next start yields a clean full run.
REQ-042 Abort scenario (SF_SEQ_ABORT_EN defined): abort at capture sample 4 -> IDLE next cycle with no done; with the macro undefined, the run completes normally.
REQ-043 Edge-parameter scenario: M=1, LEN=4 -> 4 outputs, each with acc_ld=acc_en=1; M=LEN=4 -> 1 output, out_idx=0.
